// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requester blocks and the round-robin arbiter.
// rel is the owner's one-cycle release pulse; "release" is a reserved word in SystemVerilog.
interface rr_grant_arbiter_if #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3
);
  logic [N_REQ-1:0] req;
  logic             rel;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req,
    output rel,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  rel,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: registered owner index, one-hot grant held until the owner lets go.
// Optional forced revocation after MAX_HOLD cycles is enabled by defining HOLD_TIMEOUT_EN.
module rr_grant_arbiter #(
  parameter int N_REQ    = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               resetn,
  rr_grant_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_reg,   state_next;
  logic [IDX_W-1:0] ptr_reg,     ptr_next;
  logic [IDX_W-1:0] idx_reg,     idx_next;
  logic             valid_reg,   valid_next;
  logic [N_REQ-1:0] grant_reg,   grant_next;
  logic             timeout_reg, timeout_next;

  logic [N_REQ-1:0] rot_req;
  logic [N_REQ-1:0] grant_dec;
  logic [IDX_W-1:0] pick_off;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             owner_done;
  logic             hold_expired;

  // Rotate the request vector so bit 0 is the requester at ptr; the scan is then a plain
  // lowest-set-bit search, and the winner is ptr plus that offset (wrapping in IDX_W bits).
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [IDX_W-1:0] src_idx;
      assign src_idx     = ptr_reg + IDX_W'(gi);
      assign rot_req[gi] = bus.req[src_idx];
    end
  endgenerate

  always_comb begin
    pick_off   = '0;
    pick_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        pick_off   = IDX_W'(k);
        pick_found = 1'b1;
      end
    end
  end

  assign pick_idx   = ptr_reg + pick_off;
  assign owner_done = bus.rel | ~bus.req[idx_reg];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign grant_dec[gi] = (idx_next == IDX_W'(gi));
    end
  endgenerate

`ifdef HOLD_TIMEOUT_EN
  logic [7:0] hold_cnt_reg, hold_cnt_next;

  assign hold_expired = (hold_cnt_reg == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt_reg <= '0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (state_reg == ST_IDLE) begin
      hold_cnt_next = '0;
    end else if (!(owner_done || hold_expired)) begin
      hold_cnt_next = hold_cnt_reg + 8'd1;
    end
  end
`else
  logic unused_max_hold;

  assign unused_max_hold = ^8'(MAX_HOLD);
  assign hold_expired    = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    idx_next     = idx_reg;
    valid_next   = valid_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          idx_next   = pick_idx;
          valid_next = 1'b1;
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A release or request drop takes priority; timeout only marks a forced revoke.
        if (owner_done || hold_expired) begin
          state_next   = ST_IDLE;
          valid_next   = 1'b0;
          ptr_next     = idx_reg + IDX_W'(1);
          timeout_next = ~owner_done & hold_expired;
        end
      end
      default: begin
        state_next = ST_IDLE;
        valid_next = 1'b0;
      end
    endcase
    grant_next = valid_next ? grant_dec : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      grant_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
      grant_reg   <= grant_next;
      timeout_reg <= timeout_next;
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.grant_idx   = idx_reg;
  assign bus.grant_valid = valid_reg;
  assign bus.timeout     = timeout_reg;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed and randomized checks of rr_grant_arbiter against a cycle-level reference model.
// Built with or without HOLD_TIMEOUT_EN; the model follows the same define.
module tb_rr_grant_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;
  int   cyc;

  bit   hold_en;
  bit   m_valid;
  int   m_idx;
  int   m_ptr;
  int   m_hold;
  bit   m_to;

  rr_grant_arbiter_if #(.N_REQ(8), .IDX_W(3)) bus ();

  rr_grant_arbiter #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  // One clock edge of the arbiter's rules, seen from the outside.
  task automatic model_step(input logic [7:0] r, input bit l);
    bit found;
    m_to = 1'b0;
    if (!m_valid) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_ptr + k) % 8]) begin
          found   = 1'b1;
          m_idx   = (m_ptr + k) % 8;
          m_valid = 1'b1;
          m_hold  = 0;
        end
      end
    end else if (l || !r[m_idx]) begin
      m_valid = 1'b0;
      m_ptr   = (m_idx + 1) % 8;
    end else if (hold_en && m_hold == MAX_HOLD - 1) begin
      m_valid = 1'b0;
      m_ptr   = (m_idx + 1) % 8;
      m_to    = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    eg = m_valid ? (8'h01 << m_idx) : 8'h00;
    checks++;
    assert (bus.grant === eg) else begin
      failures++;
      $error("FAIL %s grant got=%h exp=%h", tag, bus.grant, eg);
    end
    checks++;
    assert (bus.grant_idx === 3'(m_idx)) else begin
      failures++;
      $error("FAIL %s grant_idx got=%0d exp=%0d", tag, bus.grant_idx, m_idx);
    end
    checks++;
    assert (bus.grant_valid === m_valid) else begin
      failures++;
      $error("FAIL %s grant_valid got=%b exp=%b", tag, bus.grant_valid, m_valid);
    end
    checks++;
    assert (bus.timeout === m_to) else begin
      failures++;
      $error("FAIL %s timeout got=%b exp=%b", tag, bus.timeout, m_to);
    end
    checks++;
    assert ($onehot0(bus.grant)) else begin
      failures++;
      $error("FAIL %s onehot got=%h exp=at_most_one_bit", tag, bus.grant);
    end
  endtask

  task automatic expect_const(input string tag, input bit v, input int idx, input bit to);
    checks++;
    assert (bus.grant_valid === v && bus.grant_idx === 3'(idx) && bus.timeout === to)
    else begin
      failures++;
      $error("FAIL %s got=v%b/i%0d/t%b exp=v%b/i%0d/t%b", tag, bus.grant_valid,
             bus.grant_idx, bus.timeout, v, idx, to);
    end
  endtask

  task automatic cycle(input logic [7:0] r, input bit l, input string tag);
    bus.req = r;
    bus.rel = l;
    @(posedge clk);
    model_step(r, l);
    #1;
    cyc++;
    $display("cyc=%0d %s req=%h rel=%b grant=%h idx=%0d valid=%b timeout=%b", cyc, tag, r, l,
             bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout);
    check_model(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
`ifdef HOLD_TIMEOUT_EN
    hold_en = 1'b1;
`else
    hold_en = 1'b0;
`endif
    model_reset();

    // Reset with every requester active, checked before any clock edge.
    resetn  = 1'b0;
    bus.req = 8'hFF;
    bus.rel = 1'b0;
    #2;
    check_model("reset");
    checks++;
    assert (bus.grant === 8'h00) else begin
      failures++;
      $error("FAIL reset_grant got=%h exp=00", bus.grant);
    end
    @(negedge clk);
    resetn = 1'b1;

    // Single requester, held five cycles, then released.
    cycle(8'h01, 1'b0, "t2_grant");
    expect_const("t2_grant", 1'b1, 0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(8'h01, 1'b0, "t2_hold");
    expect_const("t2_held", 1'b1, 0, 1'b0);
    cycle(8'h01, 1'b1, "t2_release");
    expect_const("t2_release", 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of a grant drops it without an edge.
    cycle(8'h08, 1'b0, "rst_mid_grant");
    expect_const("rst_mid_grant", 1'b1, 3, 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    check_model("rst_async");
    @(negedge clk);
    resetn = 1'b1;

    // All requesting, owner releases every grant: indices rotate 0..7 and wrap to 0.
    for (int k = 0; k < 9; k++) begin
      cycle(8'hFF, 1'b0, "t3_grant");
      expect_const("t3_rotation", 1'b1, k % 8, 1'b0);
      cycle(8'hFF, 1'b1, "t3_idle");
      expect_const("t3_idle", 1'b0, k % 8, 1'b0);
    end

    // Owner 2 releases, then the scan from 3 wraps around to 0 before reaching 2.
    cycle(8'h04, 1'b0, "t4_own2");
    expect_const("t4_own2", 1'b1, 2, 1'b0);
    cycle(8'h04, 1'b1, "t4_rel2");
    cycle(8'h05, 1'b0, "t4_wrap");
    expect_const("t4_wrap", 1'b1, 0, 1'b0);
    cycle(8'h05, 1'b1, "t4_rel0");
    cycle(8'h05, 1'b0, "t4_next");
    expect_const("t4_next", 1'b1, 2, 1'b0);
    cycle(8'h00, 1'b1, "t4_done");

    // Owner 4 is not preempted by requester 1, then drops its request.
    cycle(8'h10, 1'b0, "t5_own4");
    cycle(8'h12, 1'b0, "t5_nopreempt");
    expect_const("t5_nopreempt", 1'b1, 4, 1'b0);
    cycle(8'h02, 1'b0, "t5_drop");
    expect_const("t5_drop", 1'b0, 4, 1'b0);
    cycle(8'h02, 1'b0, "t5_own1");
    checks++;
    assert (bus.grant === 8'h02) else begin
      failures++;
      $error("FAIL t5_grant got=%h exp=02", bus.grant);
    end
    cycle(8'h00, 1'b0, "t5_done");

    // Requester 4 never lets go: periodic revocation with the timeout enabled, else held.
    for (int p = 1; p <= 50; p++) begin
      cycle(8'h10, 1'b0, "t6_hold");
      if (hold_en) begin
        if (p % (MAX_HOLD + 1) == 0) expect_const("t6_revoke", 1'b0, 4, 1'b1);
        else                         expect_const("t6_regrant", 1'b1, 4, 1'b0);
      end else begin
        expect_const("t6_forever", 1'b1, 4, 1'b0);
      end
    end
    cycle(8'h00, 1'b0, "t6_done");

    // Random traffic with sparse and dense request patterns plus one mid-run reset.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      bit         l;
      r = 8'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
      l = ($urandom_range(0, 3) == 0);
      cycle(r, l, "rand");
      if (n == 200) begin
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_model("rand_reset");
        @(negedge clk);
        resetn = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
